// File: rtl/fp16_cvt_arbiter.sv
// fp16_cvt_arbiter: round-robin arbiter sharing one FP32->FP16 conversion lane, 2-stage valid/ready pipeline.
// Define FP16_CVT_STATS_EN to add saturating overflow/underflow counters (stat_clr/stat_ovf/stat_unf).
module fp16_cvt_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  out_valid,
  output logic [15:0]           out_data,
  output logic [ID_W-1:0]       out_id,
  input  logic                  out_ready,
`ifdef FP16_CVT_STATS_EN
  input  logic                  stat_clr,
  output logic [15:0]           stat_ovf,
  output logic [15:0]           stat_unf,
`endif
  output logic                  busy
);

  logic            s1_valid_q, s1_valid_d;
  logic [31:0]     s1_data_q, s1_data_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  logic            s2_valid_q, s2_valid_d;
  logic [15:0]     s2_data_q, s2_data_d;
  logic [ID_W-1:0] s2_id_q, s2_id_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  logic               s1_en, s2_en;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               found;
  logic [ID_W:0]      scan;
  logic [31:0]        grant_data;

  // Truncating conversion; e - 112 always lands in 1..30 so the low 5 bits suffice.
  function automatic logic [15:0] fp32_to_fp16(input logic [31:0] f);
    logic [7:0] e;
    logic [4:0] e5;
    e  = f[30:23];
    e5 = e[4:0] - 5'd16;
    if (e > 8'd142)
      return {f[31], 5'h1F, 10'h0};
    else if (e < 8'd113)
      return {f[31], 15'h0};
    else
      return {f[31], e5, f[22:13]};
  endfunction

  assign s2_en = !s2_valid_q | out_ready;
  assign s1_en = !s1_valid_q | s2_en;

  // Search upward from rr_ptr with wrap; gated by rst_n so nothing is granted in reset.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan      = '0;
    if (rst_n && s1_en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
        if (scan >= (ID_W+1)'(NUM_REQ))
          scan = scan - (ID_W+1)'(NUM_REQ);
        if (!found && req_valid[scan[ID_W-1:0]]) begin
          found                   = 1'b1;
          grant[scan[ID_W-1:0]]   = 1'b1;
          grant_idx               = scan[ID_W-1:0];
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i])
        grant_data = req_data[32*i +: 32];
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_id_d    = s2_id_q;

    if (found)
      rr_ptr_d = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);

    if (s1_en) begin
      s1_valid_d = found;
      if (found) begin
        s1_data_d = grant_data;
        s1_id_d   = grant_idx;
      end
    end

    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = fp32_to_fp16(s1_data_q);
        s2_id_d   = s1_id_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_id_q    <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_id_q    <= s2_id_d;
    end
  end

  assign req_ready = grant;
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_id    = s2_id_q;
  assign busy      = s1_valid_q | s2_valid_q;

`ifdef FP16_CVT_STATS_EN
  logic [15:0] stat_ovf_q, stat_ovf_d;
  logic [15:0] stat_unf_q, stat_unf_d;
  logic [7:0]  s1_exp;
  logic        xfer;

  assign s1_exp = s1_data_q[30:23];
  assign xfer   = s2_en & s1_valid_q;

  // Exact zeros/denormals (exp 0) are not counted as underflow.
  always_comb begin
    stat_ovf_d = stat_ovf_q;
    stat_unf_d = stat_unf_q;
    if (stat_clr) begin
      stat_ovf_d = '0;
      stat_unf_d = '0;
    end else if (xfer) begin
      if (s1_exp > 8'd142 && stat_ovf_q != 16'hFFFF)
        stat_ovf_d = stat_ovf_q + 16'd1;
      if (s1_exp >= 8'd1 && s1_exp <= 8'd112 && stat_unf_q != 16'hFFFF)
        stat_unf_d = stat_unf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ovf_q <= '0;
      stat_unf_q <= '0;
    end else begin
      stat_ovf_q <= stat_ovf_d;
      stat_unf_q <= stat_unf_d;
    end
  end

  assign stat_ovf = stat_ovf_q;
  assign stat_unf = stat_unf_q;
`endif

endmodule

// File: tb/tb_fp16_cvt_arbiter.sv
// Self-checking bench for fp16_cvt_arbiter: a capacity-2 in-order pipeline model checked every cycle,
// plus directed vectors with hand-computed FP16 results, grant orders and reset behaviour.
module tb_fp16_cvt_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  out_valid;
  logic [15:0]           out_data;
  logic [ID_W-1:0]       out_id;
  logic                  out_ready;
  logic                  busy;
`ifdef FP16_CVT_STATS_EN
  logic                  stat_clr;
  logic [15:0]           stat_ovf;
  logic [15:0]           stat_unf;
`endif

  fp16_cvt_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
`ifdef FP16_CVT_STATS_EN
    .stat_clr  (stat_clr),
    .stat_ovf  (stat_ovf),
    .stat_unf  (stat_unf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic r);
    req_valid = v;
    out_ready = r;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference conversion written from the numeric rules: rebias the exponent by -112.
  function automatic logic [15:0] model_cvt(input logic [31:0] f);
    int e;
    e = int'(f[30:23]);
    if (e > 142) return {f[31], 15'h7C00};
    if (e < 113) return {f[31], 15'h0000};
    return {f[31], 15'((e - 112) * 1024 + int'(f[22:13]))};
  endfunction

  // Model: an in-order queue of at most 2 in-flight ops; only the head can be visible at the output.
  typedef struct {
    logic [31:0] f32;
    logic [15:0] f16;
    int          id;
  } item_t;

  item_t       q[$];
  bit          head_vis = 1'b0;
  int          rr = 0;
  int unsigned m_ovf = 0;
  int unsigned m_unf = 0;

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_rdy;
    bit                 can;
    int                 g;
    int                 e;
    item_t              it;
    exp_rdy = '0;
    g       = -1;
    if (!rst_n) begin
      checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
      checkOutput("rst_busy",      32'(busy),      32'h0);
      checkOutput("rst_out_data",  32'(out_data),  32'h0);
      checkOutput("rst_out_id",    32'(out_id),    32'h0);
      q.delete();
      head_vis = 1'b0;
      rr       = 0;
      m_ovf    = 0;
      m_unf    = 0;
    end else begin
      can = (q.size() < 2) || (head_vis && out_ready);
      if (can)
        for (int k = 0; k < NUM_REQ; k++)
          if (g < 0 && req_valid[(rr + k) % NUM_REQ])
            g = (rr + k) % NUM_REQ;
      if (g >= 0) exp_rdy[g] = 1'b1;
      checkOutput("req_ready", 32'(req_ready), 32'(exp_rdy));
      checkOutput("out_valid", 32'(out_valid), 32'(head_vis));
      checkOutput("busy",      32'(busy),      32'(q.size() > 0));
      if (head_vis) begin
        checkOutput("out_data", 32'(out_data), 32'(q[0].f16));
        checkOutput("out_id",   32'(out_id),   32'(q[0].id));
      end
`ifdef FP16_CVT_STATS_EN
      checkOutput("stat_ovf", 32'(stat_ovf), m_ovf);
      checkOutput("stat_unf", 32'(stat_unf), m_unf);
`endif
      // Apply what the coming clock edge does.
      if (head_vis && out_ready) begin
        void'(q.pop_front());
        head_vis = 1'b0;
      end
      if (q.size() > 0 && !head_vis) begin
        head_vis = 1'b1;
        e = int'(q[0].f32[30:23]);
        if (e > 142 && m_ovf < 32'hFFFF) m_ovf++;
        if (e >= 1 && e <= 112 && m_unf < 32'hFFFF) m_unf++;
      end
`ifdef FP16_CVT_STATS_EN
      if (stat_clr) begin
        m_ovf = 0;
        m_unf = 0;
      end
`endif
      if (g >= 0) begin
        it.f32 = req_data[32*g +: 32];
        it.f16 = model_cvt(it.f32);
        it.id  = g;
        q.push_back(it);
        rr = (g + 1) % NUM_REQ;
      end
    end
  end

  task automatic sendOne(input int id, input logic [31:0] data, input logic [15:0] exp16, input string name);
    req_data[32*id +: 32] = data;
    applyStimulus(NUM_REQ'(1) << id, 1'b1);
    stepCycle();
    applyStimulus('0, 1'b1);
    stepCycle();
    checkOutput({name, "_valid"}, 32'(out_valid), 32'h1);
    checkOutput({name, "_data"},  32'(out_data),  32'(exp16));
    checkOutput({name, "_id"},    32'(out_id),    32'(id));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] rr_exp [4];
    int grants;
    rr_exp[0] = 16'h3C00;
    rr_exp[1] = 16'h4000;
    rr_exp[2] = 16'h4400;
    rr_exp[3] = 16'h4800;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b1;
`ifdef FP16_CVT_STATS_EN
    stat_clr  = 1'b0;
`endif
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_busy",      32'(busy),      32'h0);
    checkOutput("reset_out_data",  32'(out_data),  32'h0);

    sendOne(0, 32'h3F800000, 16'h3C00, "single");
    sendOne(1, 32'h477FE000, 16'h7BFF, "max_normal");
    sendOne(1, 32'h47800000, 16'h7C00, "overflow");
    sendOne(1, 32'h7FC00000, 16'h7C00, "nan_to_inf");
    sendOne(1, 32'h38800000, 16'h0400, "min_normal");
    sendOne(1, 32'h38000000, 16'h0000, "flush");
    sendOne(1, 32'hC0000000, 16'hC000, "negative");

    applyStimulus('0, 1'b1);
    repeat (3) stepCycle();
    req_data = {32'h41000000, 32'h40800000, 32'h40000000, 32'h3F800000};

    // Backpressure from an empty pipeline: only two operands may enter.
    applyStimulus(4'hF, 1'b0);
    grants = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (|(req_valid & req_ready)) grants++;
      stepCycle();
    end
    checkOutput("bp_grants", 32'(grants), 32'd2);
    applyStimulus('0, 1'b1);
    repeat (4) stepCycle();
    checkOutput("bp_drained", 32'(busy), 32'h0);

    // Fill both stages, then reset mid-stream.
    applyStimulus(4'hF, 1'b0);
    repeat (2) stepCycle();
    checkOutput("pre_rst_busy",      32'(busy),      32'h1);
    checkOutput("pre_rst_out_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("async_rst_busy",      32'(busy),      32'h0);
    checkOutput("async_rst_req_ready", 32'(req_ready), 32'h0);
    repeat (2) stepCycle();
    rst_n = 1'b1;
    applyStimulus(4'hF, 1'b1);

    // Round robin after reset: grants 0,1,2,3,... with results following two cycles behind.
    for (int k = 0; k < 8; k++) begin
      #1;
      checkOutput("rr_grant", 32'(req_ready), 32'(1) << (k % 4));
      if (k >= 2) begin
        checkOutput("rr_out_valid", 32'(out_valid), 32'h1);
        checkOutput("rr_out_id",    32'(out_id),    32'((k - 2) % 4));
        checkOutput("rr_out_data",  32'(out_data),  32'(rr_exp[(k - 2) % 4]));
      end
      stepCycle();
    end
    applyStimulus('0, 1'b1);
    repeat (3) stepCycle();

`ifdef FP16_CVT_STATS_EN
    sendOne(1, 32'h47800000, 16'h7C00, "st_ovf");
    sendOne(1, 32'h33800000, 16'h0000, "st_unf");
    for (int z = 0; z < 3; z++)
      sendOne(1, 32'h00000000, 16'h0000, "st_zero");
    checkOutput("stat_ovf_lit", 32'(stat_ovf), 32'd1);
    checkOutput("stat_unf_lit", 32'(stat_unf), 32'd1);
    stat_clr = 1'b1;
    stepCycle();
    stat_clr = 1'b0;
    checkOutput("stat_ovf_clr", 32'(stat_ovf), 32'd0);
    checkOutput("stat_unf_clr", 32'(stat_unf), 32'd0);
    repeat (2) stepCycle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
